// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the in-order
// writeback stage (A) and a multi-cycle unit (B) whose results queue in a small FIFO.
// A has priority; B is served on idle A cycles, and when a valid B head has waited
// STARVE_MAX cycles the pipeline is stalled (keep) so B gets the port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_we, wb_addr, wb_data       A write request
//   mc_valid, mc_ready            B enqueue handshake
//   mc_addr, mc_data              B result
//   rf_we, rf_addr, rf_data       registered register-file write (latency 1)
//   keep                          stall; A re-presents its write next cycle
//   pend_mask                     one-hot OR of destinations of valid FIFO entries
//   fifo_count                    occupied FIFO slots (including killed entries)
module wb_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       mc_valid,
  output logic                       mc_ready,
  input  logic [4:0]                 mc_addr,
  input  logic [XLEN-1:0]            mc_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_addr,
  output logic [XLEN-1:0]            rf_data,
  output logic                       keep,
  output logic [31:0]                pend_mask,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       ent_addr [DEPTH];
  logic [XLEN-1:0]  ent_data [DEPTH];
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic head_present, head_valid, req_a, grant_b, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_present = (count_q != '0);
  assign head_valid   = head_present & vld_q[rptr_q];
  assign keep         = (starve_q == SW'(STARVE_MAX)) & head_valid;
  assign mc_ready     = (count_q < CW'(DEPTH));
  assign fifo_count   = count_q;

  assign req_a   = wb_we & (wb_addr != 5'd0) & ~keep;
  assign grant_b = ~req_a & head_valid;
  // A killed head is retired without using the port, even alongside an A grant.
  assign pop     = head_present & (grant_b | ~vld_q[rptr_q]);
  // Handshakes to x0 complete but occupy no slot.
  assign push    = mc_valid & mc_ready & (mc_addr != 5'd0);

  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[rptr_q] = 1'b0;
    if (push) vld_d[wptr_q] = 1'b1;
    // A is younger than every queued B result, so its write supersedes them all,
    // including one arriving this very cycle.
    if (req_a) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (((push && (PW'(i) == wptr_q)) ? mc_addr : ent_addr[i]) == wb_addr) begin
          vld_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    starve_d = '0;
    if (head_valid && !grant_b) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[ent_addr[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else begin
      vld_q    <= vld_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push) wptr_q <= ptr_inc(wptr_q);
      rf_we <= req_a | grant_b;
      if (req_a) begin
        rf_addr <= wb_addr;
        rf_data <= wb_data;
      end else if (grant_b) begin
        rf_addr <= ent_addr[rptr_q];
        rf_data <= ent_data[rptr_q];
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ent_addr[wptr_q] <= mc_addr;
      ent_data[wptr_q] <= mc_data;
    end
  end

endmodule
